// File: rtl/bus_pkg.sv
// Shared bus definitions: default widths, counter width and the slave FSM state type.
package bus_pkg;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned DATA_W_DEF = 8;

    // Wide enough for ADDR_W, DATA_W and RD_WAIT (max 255) bit/cycle counts.
    localparam int unsigned CNT_W = 8;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StWdata,
        StMemWr,
        StMemRd,
        StSplit,
        StResume,
        StRdata,
        StDone
    } state_t;

endpackage

// File: rtl/slave_port_if.sv
// Serial slave bus: master drives select/data/resume, slave returns read data and status.
interface slave_port_if;

    logic S_SEL;
    logic S_RW;
    logic S_DIN;
    logic S_IVALID;
    logic S_RESUME;
    logic S_DOUT;
    logic S_DVALID;
    logic S_SPLIT;
    logic S_READY;

    modport master (
        output S_SEL, S_RW, S_DIN, S_IVALID, S_RESUME,
        input  S_DOUT, S_DVALID, S_SPLIT, S_READY
    );

    modport slave (
        input  S_SEL, S_RW, S_DIN, S_IVALID, S_RESUME,
        output S_DOUT, S_DVALID, S_SPLIT, S_READY
    );

endinterface

// File: rtl/slave_mem.sv
// Single-port byte store: synchronous write, registered read, contents never reset.
module slave_mem
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write on we; read data is registered every cycle from the presented address.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/slave_port.sv
// Serial bus slave: shifts in address (and write data), accesses local memory and
// shifts read data back out, optionally releasing the bus as a split transaction.
module slave_port
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned SPLIT_EN = 0,
    parameter int unsigned RD_WAIT  = 4
) (
    input logic        CLK,
    input logic        RST,
    slave_port_if.slave bus
);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_WAIT - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              rw_q;
    logic              dout_q;
    logic              dvalid_q;
    logic              split_q;
    logic              ready_q;

    logic [ADDR_W-1:0] addr_nxt;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    assign addr_nxt = {addr_q[ADDR_W-2:0], bus.S_DIN};

    // Present the completing address during the final address bit so the registered
    // read data is ready by the end of MEMRD.
    always_comb begin
        mem_addr = addr_q;
        if (state_q == StAddr) begin
            mem_addr = addr_nxt;
        end
    end

    // A reset in the MEMWR cycle drops the write.
    assign mem_we = (state_q == StMemWr) && !RST;

    slave_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .CLK   (CLK),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (data_q),
        .rdata (mem_rdata)
    );

    // Transaction FSM with registered bus outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            rw_q     <= 1'b0;
            dout_q   <= 1'b0;
            dvalid_q <= 1'b0;
            split_q  <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.S_SEL && bus.S_IVALID) begin
                        addr_q  <= addr_nxt;
                        rw_q    <= bus.S_RW;
                        cnt_q   <= CNT_W'(1);
                        state_q <= StAddr;
                    end
                end
                StAddr: begin
                    if (!bus.S_SEL) begin
                        state_q <= StIdle;
                    end else if (bus.S_IVALID) begin
                        addr_q <= addr_nxt;
                        if (cnt_q == ADDR_LAST) begin
                            cnt_q   <= '0;
                            state_q <= rw_q ? StWdata : StMemRd;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                StWdata: begin
                    if (!bus.S_SEL) begin
                        state_q <= StIdle;
                    end else if (bus.S_IVALID) begin
                        data_q <= {data_q[DATA_W-2:0], bus.S_DIN};
                        if (cnt_q == DATA_LAST) begin
                            cnt_q   <= '0;
                            state_q <= StMemWr;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                StMemWr: begin
                    ready_q <= 1'b1;
                    state_q <= StDone;
                end
                StMemRd: begin
                    cnt_q <= '0;
                    if (SPLIT_EN != 0) begin
                        data_q  <= mem_rdata;
                        split_q <= 1'b1;
                        state_q <= StSplit;
                    end else begin
                        dout_q   <= mem_rdata[DATA_W-1];
                        data_q   <= {mem_rdata[DATA_W-2:0], 1'b0};
                        dvalid_q <= 1'b1;
                        state_q  <= StRdata;
                    end
                end
                StSplit: begin
                    // S_RESUME is not looked at until the wait has fully elapsed.
                    if (cnt_q == WAIT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= StResume;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StResume: begin
                    if (bus.S_RESUME) begin
                        split_q  <= 1'b0;
                        dout_q   <= data_q[DATA_W-1];
                        data_q   <= {data_q[DATA_W-2:0], 1'b0};
                        dvalid_q <= 1'b1;
                        state_q  <= StRdata;
                    end
                end
                StRdata: begin
                    if (cnt_q == DATA_LAST) begin
                        cnt_q    <= '0;
                        dout_q   <= 1'b0;
                        dvalid_q <= 1'b0;
                        ready_q  <= 1'b1;
                        state_q  <= StDone;
                    end else begin
                        cnt_q  <= cnt_q + CNT_W'(1);
                        dout_q <= data_q[DATA_W-1];
                        data_q <= {data_q[DATA_W-2:0], 1'b0};
                    end
                end
                StDone: begin
                    ready_q <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.S_DOUT   = dout_q;
    assign bus.S_DVALID = dvalid_q;
    assign bus.S_SPLIT  = split_q;
    assign bus.S_READY  = ready_q;

endmodule

// File: tb/tb_slave_port.sv
// Bench for slave_port: DUT 0 is non-split, DUT 1 is split with RD_WAIT=4.
module tb_slave_port;

    localparam int AW  = 12;
    localparam int DW  = 8;
    localparam int RDW = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic [1:0] sel = '0, rw = '0, din = '0, iv = '0, res = '0;
    logic [1:0] dout, dvalid, split, ready;

    slave_port_if bus0 ();
    slave_port_if bus1 ();

    assign bus0.S_SEL = sel[0];  assign bus1.S_SEL = sel[1];
    assign bus0.S_RW = rw[0];    assign bus1.S_RW = rw[1];
    assign bus0.S_DIN = din[0];  assign bus1.S_DIN = din[1];
    assign bus0.S_IVALID = iv[0]; assign bus1.S_IVALID = iv[1];
    assign bus0.S_RESUME = res[0]; assign bus1.S_RESUME = res[1];
    assign dout[0] = bus0.S_DOUT;     assign dout[1] = bus1.S_DOUT;
    assign dvalid[0] = bus0.S_DVALID; assign dvalid[1] = bus1.S_DVALID;
    assign split[0] = bus0.S_SPLIT;   assign split[1] = bus1.S_SPLIT;
    assign ready[0] = bus0.S_READY;   assign ready[1] = bus1.S_READY;

    slave_port #(.ADDR_W(AW), .DATA_W(DW), .SPLIT_EN(0), .RD_WAIT(RDW)) dut0 (
        .CLK (CLK), .RST (RST), .bus (bus0)
    );
    slave_port #(.ADDR_W(AW), .DATA_W(DW), .SPLIT_EN(1), .RD_WAIT(RDW)) dut1 (
        .CLK (CLK), .RST (RST), .bus (bus1)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Reference memory and list of written addresses per DUT.
    logic [7:0] ref_mem [2][4096];
    int wl [2][64];
    int wn [2] = '{0, 0};

    // Read timing from the rules: MEMRD takes one cycle; a split read then waits
    // RD_WAIT cycles and for the resume, and data starts the cycle after the resume.
    function automatic int exp_first(input int p, input int rk);
        return (p == 0) ? 2 : rk + 1;
    endfunction

    task automatic send_bits(input int p, input logic [31:0] val, input int n, input bit gap);
        for (int i = n - 1; i >= 0; i--) begin
            if (gap) begin
                sel[p] = 1'b1; iv[p] = 1'b0; @(negedge CLK);
            end
            sel[p] = 1'b1; iv[p] = 1'b1; din[p] = val[i]; @(negedge CLK);
        end
    endtask

    task automatic do_write(input int p, input int a, input logic [7:0] d, input bit gap,
                            output int rdy_cnt, output int rdy_k);
        rw[p] = 1'b1;
        send_bits(p, a, AW, gap);
        send_bits(p, {24'd0, d}, DW, gap);
        rdy_cnt = 0; rdy_k = 0;
        for (int k = 1; k <= 12; k++) begin
            if (ready[p]) begin rdy_cnt++; if (rdy_k == 0) rdy_k = k; end
            iv[p] = 1'b0; din[p] = 1'b0;
            @(negedge CLK);
        end
        sel[p] = 1'b0;
        @(negedge CLK);
    endtask

    task automatic do_read(input int p, input int a, input int rk, input int ek,
                           output logic [7:0] data, output int nvalid, output int first_k,
                           output int last_k, output int rdy_cnt, output int rdy_k,
                           output int split_first, output int split_cnt, output int dout_bad);
        rw[p] = 1'b0;
        send_bits(p, a, AW, 1'b0);
        data = '0; nvalid = 0; first_k = 0; last_k = 0; rdy_cnt = 0; rdy_k = 0;
        split_first = 0; split_cnt = 0; dout_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            if (dvalid[p]) begin
                nvalid++; data = {data[6:0], dout[p]};
                if (first_k == 0) first_k = k;
                last_k = k;
            end else if (dout[p] !== 1'b0) begin
                dout_bad++;
            end
            if (ready[p]) begin rdy_cnt++; if (rdy_k == 0) rdy_k = k; end
            if (split[p]) begin split_cnt++; if (split_first == 0) split_first = k; end
            iv[p] = 1'b0; din[p] = 1'b0;
            res[p] = (k == rk) || (k == ek);
            // Select wiggles after the address phase must not matter.
            sel[p] = 1'($urandom_range(0, 1));
            @(negedge CLK);
        end
        res[p] = 1'b0; sel[p] = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        for (int p = 0; p < 2; p++) begin
            n_checks++; if (dout[p] !== 1'b0) begin n_fail++; $display("FAIL reset_dout[%0d] got %b exp 0", p, dout[p]); end
            n_checks++; if (dvalid[p] !== 1'b0) begin n_fail++; $display("FAIL reset_dvalid[%0d] got %b exp 0", p, dvalid[p]); end
            n_checks++; if (split[p] !== 1'b0) begin n_fail++; $display("FAIL reset_split[%0d] got %b exp 0", p, split[p]); end
            n_checks++; if (ready[p] !== 1'b0) begin n_fail++; $display("FAIL reset_ready[%0d] got %b exp 0", p, ready[p]); end
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_write_read;
        int rc, rk, nv, fk, lk, rdc, rdk, sf, sc, db;
        logic [7:0] d;
        do_write(0, 12'h356, 8'hAD, 1'b0, rc, rk);
        ref_mem[0][12'h356] = 8'hAD; wl[0][wn[0]++] = 12'h356;
        n_checks++; if (rc !== 1) begin n_fail++; $display("FAIL wr_ready_count got %0d exp 1", rc); end
        n_checks++; if (rk !== 2) begin n_fail++; $display("FAIL wr_ready_cycle got %0d exp 2", rk); end
        do_read(0, 12'h356, 0, 0, d, nv, fk, lk, rdc, rdk, sf, sc, db);
        n_checks++; if (d !== 8'hAD) begin n_fail++; $display("FAIL rd_data got %h exp ad", d); end
        n_checks++; if (nv !== 8) begin n_fail++; $display("FAIL rd_nvalid got %0d exp 8", nv); end
        n_checks++; if (fk !== 2) begin n_fail++; $display("FAIL rd_latency got %0d exp 2", fk); end
        n_checks++; if (lk - fk + 1 !== 8) begin n_fail++; $display("FAIL rd_contig got %0d exp 8", lk - fk + 1); end
        n_checks++; if (rdk !== 10 || rdc !== 1) begin n_fail++; $display("FAIL rd_ready got k=%0d n=%0d exp k=10 n=1", rdk, rdc); end
        n_checks++; if (sc !== 0) begin n_fail++; $display("FAIL rd_nosplit got %0d exp 0", sc); end
        n_checks++; if (db !== 0) begin n_fail++; $display("FAIL rd_dout_idle got %0d exp 0", db); end
    endtask

    task automatic test_gapped;
        int rc, rk, nv, fk, lk, rdc, rdk, sf, sc, db;
        logic [7:0] d;
        do_write(0, 12'h2A5, 8'h5C, 1'b1, rc, rk);
        ref_mem[0][12'h2A5] = 8'h5C; wl[0][wn[0]++] = 12'h2A5;
        n_checks++; if (rc !== 1 || rk !== 2) begin n_fail++; $display("FAIL gap_ready got k=%0d n=%0d exp k=2 n=1", rk, rc); end
        do_read(0, 12'h2A5, 0, 0, d, nv, fk, lk, rdc, rdk, sf, sc, db);
        n_checks++; if (d !== 8'h5C) begin n_fail++; $display("FAIL gap_data got %h exp 5c", d); end
        n_checks++; if (d !== ref_mem[0][12'h2A5] || nv !== 8) begin n_fail++; $display("FAIL gap_nvalid got %0d exp 8", nv); end
    endtask

    task automatic test_split;
        int rc, rk, nv, fk, lk, rdc, rdk, sf, sc, db;
        logic [7:0] d;
        do_write(1, 12'h356, 8'hAD, 1'b1, rc, rk);
        ref_mem[1][12'h356] = 8'hAD; wl[1][wn[1]++] = 12'h356;
        n_checks++; if (rc !== 1 || rk !== 2) begin n_fail++; $display("FAIL sp_wr_ready got k=%0d n=%0d exp k=2 n=1", rk, rc); end
        // Early resume in the SPLIT wait, real resume 10 cycles after S_SPLIT rises.
        do_read(1, 12'h356, 12, 3, d, nv, fk, lk, rdc, rdk, sf, sc, db);
        n_checks++; if (d !== 8'hAD) begin n_fail++; $display("FAIL sp_data got %h exp ad", d); end
        n_checks++; if (sf !== 2) begin n_fail++; $display("FAIL sp_split_start got %0d exp 2", sf); end
        n_checks++; if (sc !== 11) begin n_fail++; $display("FAIL sp_split_len got %0d exp 11", sc); end
        n_checks++; if (fk !== 13 || nv !== 8 || lk !== 20) begin n_fail++; $display("FAIL sp_dvalid got first=%0d n=%0d last=%0d exp 13/8/20", fk, nv, lk); end
        n_checks++; if (rdk !== 21 || rdc !== 1) begin n_fail++; $display("FAIL sp_ready got k=%0d n=%0d exp k=21 n=1", rdk, rdc); end
        n_checks++; if (db !== 0) begin n_fail++; $display("FAIL sp_dout_idle got %0d exp 0", db); end
        // Resume pulse in the last SPLIT cycle ignored; earliest accepted resume next cycle.
        do_read(1, 12'h356, RDW + 2, RDW + 1, d, nv, fk, lk, rdc, rdk, sf, sc, db);
        n_checks++; if (d !== 8'hAD) begin n_fail++; $display("FAIL sp_min_data got %h exp ad", d); end
        n_checks++; if (fk !== RDW + 3) begin n_fail++; $display("FAIL sp_min_latency got %0d exp %0d", fk, RDW + 3); end
        n_checks++; if (sc !== RDW + 1) begin n_fail++; $display("FAIL sp_min_split got %0d exp %0d", sc, RDW + 1); end
    endtask

    task automatic test_abort;
        int rc, rk, nv, fk, lk, rdc, rdk, sf, sc, db;
        logic [7:0] d;
        do_write(0, 12'h001, 8'h3C, 1'b0, rc, rk);
        ref_mem[0][12'h001] = 8'h3C; wl[0][wn[0]++] = 12'h001;
        // Abort after five data bits.
        rw[0] = 1'b1;
        send_bits(0, 12'h001, AW, 1'b0);
        send_bits(0, 32'(8'hC3 >> 3), 5, 1'b0);
        rc = 0;
        for (int k = 0; k < 12; k++) begin
            sel[0] = 1'b0; iv[0] = 1'b0;
            if (ready[0]) rc++;
            @(negedge CLK);
        end
        n_checks++; if (rc !== 0) begin n_fail++; $display("FAIL abort_wdata_ready got %0d exp 0", rc); end
        // Abort after six address bits.
        send_bits(0, 6'h3F, 6, 1'b0);
        rc = 0;
        for (int k = 0; k < 12; k++) begin
            sel[0] = 1'b0; iv[0] = 1'b0;
            if (ready[0]) rc++;
            @(negedge CLK);
        end
        n_checks++; if (rc !== 0) begin n_fail++; $display("FAIL abort_addr_ready got %0d exp 0", rc); end
        do_read(0, 12'h001, 0, 0, d, nv, fk, lk, rdc, rdk, sf, sc, db);
        n_checks++; if (d !== ref_mem[0][12'h001]) begin n_fail++; $display("FAIL abort_data got %h exp %h", d, ref_mem[0][12'h001]); end
        n_checks++; if (nv !== 8 || rdc !== 1) begin n_fail++; $display("FAIL abort_rd got n=%0d rdy=%0d exp 8/1", nv, rdc); end
    endtask

    task automatic test_reset_rdata;
        int seen, nv, fk, lk, rdc, rdk, sf, sc, db;
        bit hit;
        logic [7:0] d;
        rw[0] = 1'b0;
        send_bits(0, 12'h356, AW, 1'b0);
        seen = 0; hit = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (!hit) begin
                if (dvalid[0]) seen++;
                iv[0] = 1'b0;
                if (seen == 3) begin
                    RST = 1'b1;
                    @(negedge CLK);
                    hit = 1'b1;
                    n_checks++; if (dout[0] !== 1'b0) begin n_fail++; $display("FAIL rst_rd_dout got %b exp 0", dout[0]); end
                    n_checks++; if (dvalid[0] !== 1'b0) begin n_fail++; $display("FAIL rst_rd_dvalid got %b exp 0", dvalid[0]); end
                    n_checks++; if (ready[0] !== 1'b0) begin n_fail++; $display("FAIL rst_rd_ready got %b exp 0", ready[0]); end
                    n_checks++; if (split[0] !== 1'b0) begin n_fail++; $display("FAIL rst_rd_split got %b exp 0", split[0]); end
                    RST = 1'b0; sel[0] = 1'b0;
                end else begin
                    @(negedge CLK);
                end
            end
        end
        n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL rst_rd_reached got %b exp 1", hit); end
        do_read(0, 12'h356, 0, 0, d, nv, fk, lk, rdc, rdk, sf, sc, db);
        n_checks++; if (d !== ref_mem[0][12'h356] || nv !== 8) begin n_fail++; $display("FAIL rst_rd_after got %h n=%0d exp %h n=8", d, nv, ref_mem[0][12'h356]); end
    endtask

    task automatic test_random;
        int p, a, rc, rk, ek, idx, nv, fk, lk, rdc, rdk, sf, sc, db;
        logic [7:0] wd, d;
        bit gap;
        for (int it = 0; it < 12; it++) begin
            p = $urandom_range(0, 1);
            a = $urandom_range(0, 4095);
            wd = 8'($urandom_range(0, 255));
            gap = 1'($urandom_range(0, 1));
            do_write(p, a, wd, gap, rc, rk);
            ref_mem[p][a] = wd; wl[p][wn[p]++] = a;
            n_checks++; if (rc !== 1 || rk !== 2) begin n_fail++; $display("FAIL rnd_wr_ready it=%0d got k=%0d n=%0d exp k=2 n=1", it, rk, rc); end
            idx = $urandom_range(0, wn[p] - 1);
            rk = RDW + 2 + $urandom_range(0, 10);
            ek = $urandom_range(1, RDW + 1);
            do_read(p, wl[p][idx], rk, ek, d, nv, fk, lk, rdc, rdk, sf, sc, db);
            n_checks++; if (d !== ref_mem[p][wl[p][idx]]) begin n_fail++; $display("FAIL rnd_data it=%0d p=%0d got %h exp %h", it, p, d, ref_mem[p][wl[p][idx]]); end
            n_checks++; if (fk !== exp_first(p, rk) || nv !== 8) begin n_fail++; $display("FAIL rnd_timing it=%0d got first=%0d n=%0d exp %0d/8", it, fk, nv, exp_first(p, rk)); end
            n_checks++; if (rdk !== exp_first(p, rk) + DW || rdc !== 1) begin n_fail++; $display("FAIL rnd_ready it=%0d got k=%0d exp %0d", it, rdk, exp_first(p, rk) + DW); end
            n_checks++; if (sc !== ((p == 0) ? 0 : rk - 1) || db !== 0) begin n_fail++; $display("FAIL rnd_split it=%0d got split=%0d bad=%0d", it, sc, db); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_gapped();
        test_split();
        test_abort();
        test_reset_rdata();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/slave_port.md
SLAVE_PORT -- requirements
Module: slave_port

Interface
REQ-001: Parameter ADDR_W, default 12: local address width; memory depth is 2**ADDR_W bytes.
REQ-002: Parameter DATA_W, default 8: data width.
REQ-003: Parameter SPLIT_EN, default 0: when 1, reads are split transactions.
REQ-004: Parameter RD_WAIT, default 4: split-read delay in cycles, range 1..255.
REQ-005: CLK  in  1  clock; one clock domain; all logic on the rising edge.
REQ-006: RST  in  1  reset; synchronous, active-high.
REQ-007: S_SEL  in  1  slave selected by the upstream address decoder; frame active while high.
REQ-008: S_RW  in  1  1 = write, 0 = read; sampled with the first address bit.
REQ-009: S_DIN  in  1  serial data from master, MSB first.
REQ-010: S_IVALID  in  1  S_DIN bit valid this cycle.
REQ-011: S_RESUME  in  1  bus re-granted to this slave after a split.
REQ-012: S_DOUT  out  1  serial read data to master, MSB first.
REQ-013: S_DVALID  out  1  S_DOUT bit valid this cycle.
REQ-014: S_SPLIT  out  1  bus-release request while a split read is pending.
REQ-015: S_READY  out  1  one-cycle pulse when a transaction completes.

Function
REQ-016: FSM states: IDLE, ADDR, WDATA, MEMWR, MEMRD, SPLIT, RESUME, RDATA, DONE.
REQ-017: IDLE -> ADDR on S_SEL=1 & S_IVALID=1; that bit is address MSB; latch S_RW in the same cycle.
REQ-018: ADDR: shift one bit per S_IVALID=1 cycle; S_IVALID=0 cycles hold state; after ADDR_W bits go to WDATA if write, MEMRD if read.
REQ-019: WDATA: shift DATA_W bits on S_IVALID=1; after the last bit go to MEMWR.
REQ-020: MEMWR: write the byte to mem[addr] in one cycle, then go to DONE.
REQ-021: MEMRD: one-cycle synchronous read into the shift register; then RDATA if SPLIT_EN=0, SPLIT if SPLIT_EN=1.
REQ-022: SPLIT: hold S_SPLIT=1; the counter runs RD_WAIT cycles, then go to RESUME.
REQ-023: RESUME: hold S_SPLIT=1 until S_RESUME=1; in that cycle drop S_SPLIT and go to RDATA.
REQ-024: S_RESUME=1 that arrives before the counter expires is ignored.
REQ-025: RDATA: drive DATA_W bits MSB first on S_DOUT for DATA_W consecutive cycles with S_DVALID=1; then DONE.
REQ-026: DONE: S_READY=1 for exactly one cycle, then IDLE.
REQ-027: Read latency with SPLIT_EN=0 is 1 cycle from the last address bit to the first S_DVALID.
REQ-028: Read latency with SPLIT_EN=1 is 1+RD_WAIT cycles plus S_RESUME wait.
REQ-029: S_SEL=0 in ADDR or WDATA aborts to IDLE with no write and no S_READY.
REQ-030: S_SEL changes during MEMRD, SPLIT, RESUME or RDATA are ignored.
REQ-031: Address is a pure ADDR_W-bit index; no wrap logic is needed.
REQ-032: S_DOUT=0 whenever S_DVALID=0.

Reset
REQ-033: RST=1 forces IDLE and clears the counters and shift registers.
REQ-034: Under RST=1, S_DOUT, S_DVALID, S_SPLIT and S_READY are 0 in the next cycle.
REQ-035: Reset mid-transaction abandons the transaction; an in-progress write is not committed unless MEMWR has already executed.
REQ-036: Memory contents are not reset.

Structure
REQ-037: FSM state enum and default ADDR_W/DATA_W constants live in shared package bus_pkg.
REQ-038: Storage is sub-module slave_mem: single-port, synchronous write, 1-cycle registered read, no reset.

Verification
REQ-039: SPLIT_EN=0; write addr 0x356, data 0xAD -> S_READY pulse; memory location 0x356 holds 0xAD.
REQ-040: Read back addr 0x356 -> S_DVALID high 8 consecutive cycles, S_DOUT = 1,0,1,0,1,1,0,1; S_READY pulse the next cycle.
REQ-041: SPLIT_EN=1, RD_WAIT=4; read 0x356 -> S_SPLIT high from MEMRD+1; S_RESUME given 10 cycles later -> 0xAD shifted out; early S_RESUME ignored.
REQ-042: Write with S_IVALID gapped every other cycle -> same result as the ungapped write.
REQ-043: S_SEL dropped after 5 data bits of a write to 0x001 -> no S_READY; 0x001 is unchanged.
REQ-044: RST asserted during RDATA -> outputs 0 the next cycle; a following read returns the correct data.
